rmgmt_mem_bridge: RTL

Core-side responder for RISC-MGMT extension memory requests. Accepts an extension's request (address, store data, read/write enables, byte enables), arbitrates it against the execute stage's own data-memory request, drives the single data-side generic bus, and returns load data and a busy/done handshake to the extension. Sits between the RISC-MGMT extension wrapper and the data bus in the two-stage pipeline.

---
 rtl/rmgmt_bridge_pkg.sv | 22 ++
 rtl/rmgmt_mem_bridge.sv | 129 ++++++++++++
 2 files changed

// File: rtl/rmgmt_bridge_pkg.sv
// Shared definitions for the RISC-MGMT memory bridge: the bridge FSM state
// encoding and the alignment rule the hazard unit also applies.
package rmgmt_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PIPE_XFER = 2'd1,
    RM_XFER   = 2'd2,
    RM_DONE   = 2'd3
  } bridge_state_e;

  // Word accesses need addr[1:0]==0; halfword accesses (either lane pair) need addr[0]==0.
  function automatic logic rm_is_misaligned(input logic [1:0] addr_lsb,
                                            input logic [3:0] byte_en);
    logic word_bad;
    logic half_bad;
    word_bad = (byte_en == 4'b1111) && (addr_lsb != 2'b00);
    half_bad = ((byte_en == 4'b0011) || (byte_en == 4'b1100)) && addr_lsb[0];
    return word_bad || half_bad;
  endfunction

endpackage

// File: rtl/rmgmt_mem_bridge.sv
// Arbitrates RISC-MGMT extension memory requests against the execute stage on
// the single data bus; the bus is driven only from latched request registers.
module rmgmt_mem_bridge
  import rmgmt_bridge_pkg::*;
#(
  parameter int RM_MAX_WAIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        rm_req_mem,
  input  logic [31:0] rm_mem_addr,
  input  logic [31:0] rm_mem_store,
  input  logic        rm_mem_ren,
  input  logic        rm_mem_wen,
  input  logic [3:0]  rm_mem_byte_en,
  output logic [31:0] rm_mem_load,
  output logic        rm_mem_busy,
  output logic        rm_misaligned,
  input  logic        flush,
  input  logic        pipe_ren,
  input  logic        pipe_wen,
  input  logic [31:0] pipe_addr,
  input  logic [31:0] pipe_wdata,
  input  logic [3:0]  pipe_byte_en,
  output logic [31:0] pipe_rdata,
  output logic        pipe_busy,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_ren,
  output logic        bus_wen,
  output logic [3:0]  bus_byte_en,
  input  logic [31:0] bus_rdata,
  input  logic        bus_busy
);

  localparam logic [3:0] WAIT_MAX = 4'(RM_MAX_WAIT);

  bridge_state_e state_reg, state_next;
  logic [3:0]    wait_cnt_reg;
  logic          drop_reg, drop_next;
  logic [31:0]   load_reg;
  logic [31:0]   req_addr_reg, req_wdata_reg;
  logic [3:0]    req_be_reg;
  logic          req_ren_reg, req_wen_reg;

  logic rm_rw, rm_valid, pipe_valid, wait_full;
  logic rm_grant, pipe_grant, in_xfer, rm_capture;

  assign rm_rw         = rm_req_mem & (rm_mem_ren | rm_mem_wen);
  assign rm_misaligned = rm_rw & rm_is_misaligned(rm_mem_addr[1:0], rm_mem_byte_en);
  assign rm_valid      = rm_rw & ~rm_misaligned;
  assign pipe_valid    = pipe_ren | pipe_wen;
  assign wait_full     = (wait_cnt_reg == WAIT_MAX);

  assign rm_grant   = (state_reg == IDLE) & rm_valid & ~flush & (~pipe_valid | wait_full);
  assign pipe_grant = (state_reg == IDLE) & ~rm_grant & pipe_valid;

  always_comb begin
    state_next = state_reg;
    drop_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rm_grant)        state_next = RM_XFER;
        else if (pipe_grant) state_next = PIPE_XFER;
      end
      PIPE_XFER: if (!bus_busy) state_next = IDLE;
      RM_XFER: begin
        // A flush cannot abort the bus cycle; it only suppresses the result.
        if (!bus_busy) state_next = (drop_reg | flush) ? IDLE : RM_DONE;
        else           drop_next  = drop_reg | flush;
      end
      RM_DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign rm_capture = (state_reg == RM_XFER) & ~bus_busy & req_ren_reg & ~drop_reg & ~flush;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= 4'd0;
      drop_reg      <= 1'b0;
      load_reg      <= 32'd0;
      req_addr_reg  <= 32'd0;
      req_wdata_reg <= 32'd0;
      req_be_reg    <= 4'd0;
      req_ren_reg   <= 1'b0;
      req_wen_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      drop_reg  <= drop_next;
      if (rm_capture) load_reg <= bus_rdata;

      // Simultaneous read and write enables are treated as a write.
      if (rm_grant) begin
        req_addr_reg  <= rm_mem_addr;
        req_wdata_reg <= rm_mem_store;
        req_be_reg    <= rm_mem_byte_en;
        req_ren_reg   <= rm_mem_ren & ~rm_mem_wen;
        req_wen_reg   <= rm_mem_wen;
      end else if (pipe_grant) begin
        req_addr_reg  <= pipe_addr;
        req_wdata_reg <= pipe_wdata;
        req_be_reg    <= pipe_byte_en;
        req_ren_reg   <= pipe_ren & ~pipe_wen;
        req_wen_reg   <= pipe_wen;
      end

      if (~rm_req_mem | flush | rm_grant)
        wait_cnt_reg <= 4'd0;
      else if (pipe_grant & rm_valid & ~wait_full)
        wait_cnt_reg <= wait_cnt_reg + 4'd1;
    end
  end

  assign in_xfer     = (state_reg == PIPE_XFER) | (state_reg == RM_XFER);
  assign bus_ren     = req_ren_reg & in_xfer;
  assign bus_wen     = req_wen_reg & in_xfer;
  assign bus_addr    = req_addr_reg;
  assign bus_wdata   = req_wdata_reg;
  assign bus_byte_en = req_be_reg;

  assign rm_mem_load = load_reg;
  assign rm_mem_busy = rm_valid & (state_reg != RM_DONE);
  assign pipe_rdata  = bus_rdata;
  assign pipe_busy   = pipe_valid & ~((state_reg == PIPE_XFER) & ~bus_busy);

endmodule
